// File: rtl/binconv_pool_pe_seq_if.sv
// Handshake bundle for binconv_pool_pe_seq.
//
// Valid/ready rule, applied to both the beat side (in_*) and the result side
// (out_*): a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer keeps valid and its payload stable until that edge.
// The consumer may drive ready without waiting for valid.
//
// state mirrors the PE sequencer for observers: 0 = ACC, 1 = POOL, 2 = OUT.
interface binconv_pool_pe_seq_if #(
  parameter int D             = 512,
  parameter int CHUNK         = 64,
  parameter int FH            = 3,
  parameter int FW            = 3,
  parameter int POOL_H        = 2,
  parameter int POOL_W        = 2,
  parameter int STRIDE_H      = 1,
  parameter int STRIDE_W      = 1,
  parameter int NORMREF_WIDTH = 14
);
  localparam int IN_H           = (POOL_H - 1) * STRIDE_H + FH;
  localparam int IN_W           = (POOL_W - 1) * STRIDE_W + FW;
  localparam int NK             = POOL_H * POOL_W;
  localparam int CONV_OUT_WIDTH = $clog2(D * FH * FW + 1);
  localparam int PINDEX_WIDTH   = (NK > 1) ? $clog2(NK) : 1;

  logic                           in_valid;
  logic                           in_ready;
  logic [CHUNK*IN_H*IN_W-1:0]     data_in;
  logic [CHUNK*FH*FW-1:0]         weight_in;
  logic [NORMREF_WIDTH-1:0]       norm_ref;
  logic                           s;
  logic                           out_valid;
  logic                           out_ready;
  logic                           data_out;
  logic [PINDEX_WIDTH-1:0]        pindex;
  logic [CONV_OUT_WIDTH-1:0]      max_conv;
  logic [1:0]                     state;

  // Window feeder / result consumer side.
  modport master (
    output in_valid, data_in, weight_in, norm_ref, s, out_ready,
    input  in_ready, out_valid, data_out, pindex, max_conv, state
  );

  // Processing-element side.
  modport slave (
    input  in_valid, data_in, weight_in, norm_ref, s, out_ready,
    output in_ready, out_valid, data_out, pindex, max_conv, state
  );
endinterface

// File: rtl/binconv_pool_pe_seq.sv
// binconv_pool_pe_seq: binary-convolution PE with fused pooling.
// Folds the channel depth D over D/CHUNK beats; each beat adds the
// XNOR-popcount of every conv position of one pooling window. After the
// last beat one POOL cycle picks the max (s=0) or min (s=1) sum, lowest
// index on ties, and binarizes it against norm_ref (1 fractional bit).
// The result is then held on the out_* handshake until consumed.
//
// Optional build macro: BINCONV_PE_DBG_EN adds output conv_out carrying all
// NK final sums (position 0 in the MSBs), captured in the POOL cycle.
module binconv_pool_pe_seq #(
  parameter int D             = 512,
  parameter int CHUNK         = 64,
  parameter int FH            = 3,
  parameter int FW            = 3,
  parameter int POOL_H        = 2,
  parameter int POOL_W        = 2,
  parameter int STRIDE_H      = 1,
  parameter int STRIDE_W      = 1,
  parameter int NORMREF_WIDTH = 14,
  localparam int NK             = POOL_H * POOL_W,
  localparam int CONV_OUT_WIDTH = $clog2(D * FH * FW + 1)
) (
  input logic clk,
  input logic rst_n,
  binconv_pool_pe_seq_if.slave bus
`ifdef BINCONV_PE_DBG_EN
  ,
  output logic [NK*CONV_OUT_WIDTH-1:0] conv_out
`endif
);

  localparam int IN_H         = (POOL_H - 1) * STRIDE_H + FH;
  localparam int IN_W         = (POOL_W - 1) * STRIDE_W + FW;
  localparam int NPIX_IN      = IN_H * IN_W;
  localparam int NPIX_K       = FH * FW;
  localparam int NBEAT        = D / CHUNK;
  localparam int PINDEX_WIDTH = (NK > 1) ? $clog2(NK) : 1;
  localparam int BW           = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int CW           = CONV_OUT_WIDTH;

  // Parameter sanity, reported at elaboration.
  if (D % CHUNK != 0) begin : g_chk_depth
    $error("binconv_pool_pe_seq: D must be a multiple of CHUNK");
  end
  if (NORMREF_WIDTH != CONV_OUT_WIDTH + 1) begin : g_chk_ref
    $error("binconv_pool_pe_seq: NORMREF_WIDTH must equal CONV_OUT_WIDTH+1");
  end

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_POOL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                    state;
  logic [BW-1:0]             beat_cnt;
  logic [CW-1:0]             acc [NK];
  logic                      s_q;
  logic [NORMREF_WIDTH-1:0]  ref_q;
  logic                      out_valid_q;
  logic                      data_out_q;
  logic [PINDEX_WIDTH-1:0]   pindex_q;
  logic [CW-1:0]             max_conv_q;

  // Bit position of channel b of input pixel (r,c); pixels are MSB-first.
  function automatic int din_bit(input int k, input int fr, input int fc, input int b);
    int r;
    int c;
    r = (k / POOL_W) * STRIDE_H + fr;
    c = (k % POOL_W) * STRIDE_W + fc;
    return (NPIX_IN - 1 - (r * IN_W + c)) * CHUNK + b;
  endfunction

  // Bit position of channel b of kernel tap (fr,fc), same MSB-first order.
  function automatic int wt_bit(input int fr, input int fc, input int b);
    return (NPIX_K - 1 - (fr * FW + fc)) * CHUNK + b;
  endfunction

  // XNOR-popcount of the current beat for every conv position in the window.
  logic [CW-1:0] beat_pc [NK];
  logic          xb;
  always_comb begin
    xb = 1'b0;
    for (int k = 0; k < NK; k++) begin
      beat_pc[k] = '0;
      for (int fr = 0; fr < FH; fr++) begin
        for (int fc = 0; fc < FW; fc++) begin
          for (int b = 0; b < CHUNK; b++) begin
            xb = bus.data_in[din_bit(k, fr, fc, b)] ~^ bus.weight_in[wt_bit(fr, fc, b)];
            beat_pc[k] = beat_pc[k] + {{(CW-1){1'b0}}, xb};
          end
        end
      end
    end
  end

  // Pool selection over the finished sums; a later position only wins when
  // strictly better, so ties keep the lowest index.
  logic [CW-1:0]           sel_val;
  logic [PINDEX_WIDTH-1:0] sel_idx;
  always_comb begin
    sel_val = acc[0];
    sel_idx = '0;
    for (int k = 1; k < NK; k++) begin
      if (s_q ? (acc[k] < sel_val) : (acc[k] > sel_val)) begin
        sel_val = acc[k];
        sel_idx = PINDEX_WIDTH'(k);
      end
    end
  end

  // Threshold compare: the sum is doubled to line up with the fractional bit
  // of norm_ref, then compared unsigned.
  logic [NORMREF_WIDTH-1:0] sel_x2;
  logic                     thr_bit;
  always_comb begin
    sel_x2  = NORMREF_WIDTH'({sel_val, 1'b0});
    thr_bit = s_q ? (sel_x2 < ref_q) : (sel_x2 >= ref_q);
  end

  // Sequencer: accumulate beats, pool for one cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      beat_cnt    <= '0;
      for (int k = 0; k < NK; k++) acc[k] <= '0;
      s_q         <= 1'b0;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= 1'b0;
      pindex_q    <= '0;
      max_conv_q  <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            // First beat loads, so no separate clear cycle is needed.
            for (int k = 0; k < NK; k++) begin
              acc[k] <= (beat_cnt == '0) ? beat_pc[k] : acc[k] + beat_pc[k];
            end
            if (beat_cnt == BW'(NBEAT - 1)) begin
              beat_cnt <= '0;
              s_q      <= bus.s;
              ref_q    <= bus.norm_ref;
              state    <= ST_POOL;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        ST_POOL: begin
          max_conv_q  <= sel_val;
          pindex_q    <= sel_idx;
          data_out_q  <= thr_bit;
          out_valid_q <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

`ifdef BINCONV_PE_DBG_EN
  // Snapshot of every position's final sum, taken alongside the pooled result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_out <= '0;
    end else if (state == ST_POOL) begin
      for (int k = 0; k < NK; k++) begin
        conv_out[(NK-1-k)*CW +: CW] <= acc[k];
      end
    end
  end
`else
  // Default build: final sums are only visible through max_conv.
`endif

  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.pindex    = pindex_q;
  assign bus.max_conv  = max_conv_q;
  assign bus.state     = state;

endmodule
